// File: rtl/tpu_result_writer_pkg.sv
// Shared sizes, FSM encoding and lane helpers for the TPU result writer.
// Lane k of a result row is the byte at bit offset TPU_RW_LANE_LSB(k).
`ifndef TPU_RW_LANE_LSB
`define TPU_RW_LANE_LSB(k) (LANE_W * (LANES - 1 - (k)))
`endif

package tpu_result_writer_pkg;

    localparam int ROWS        = 16;
    localparam int LANE_W      = 8;
    localparam int LANES       = 16;
    localparam int DATA_W      = LANES * LANE_W;
    localparam int ADDR_W      = 16;
    localparam int ADDR_STRIDE = 1;
    localparam int FIFO_DEPTH  = 4;
    localparam int CNT_W       = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        FINISH  = 2'd3
    } wr_state_e;

    // Clamp every signed lane with its sign bit set to zero when en is high.
    function automatic logic [DATA_W-1:0] relu_row(input logic [DATA_W-1:0] row, input logic en);
        logic [DATA_W-1:0] r;
        r = row;
        for (int k = 0; k < LANES; k++) begin
            if (en && row[`TPU_RW_LANE_LSB(k) + LANE_W - 1])
                r[`TPU_RW_LANE_LSB(k) +: LANE_W] = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/tpu_result_writer_fifo.sv
// result_fifo: flop-based row FIFO. The head row is read straight from the storage
// flops, so the write port sees data in the same cycle the row becomes valid.
module result_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign cnt_o   = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tpu_result_writer.sv
// Captures TPU result rows, buffers them, and writes them (optionally ReLU'd) to the
// global buffer at base + row*stride. Rows cannot be stalled; overrun is flagged sticky.
module tpu_result_writer
    import tpu_result_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tpu_out_valid,
    input  logic [DATA_W-1:0] tpu_DO,
    input  logic              tpu_done,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              relu_en,
    output logic              gb_valid,
    output logic [ADDR_W-1:0] gb_addr,
    output logic [DATA_W-1:0] gb_data,
    input  logic              gb_ready,
    output logic              busy,
    output logic              tile_done,
    output logic              overflow
);
    localparam int FPW = $clog2(FIFO_DEPTH);

    wr_state_e         state_q;
    logic [CNT_W-1:0]  in_cnt_q;
    logic [ADDR_W-1:0] out_cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic              relu_q;
    logic              busy_q, tile_done_q, ovf_q;

    logic              push, pop, fifo_full, fifo_empty;
    logic [FPW:0]      fifo_cnt;
    logic [DATA_W-1:0] head;

    assign push = tpu_out_valid && (state_q != DRAIN);
    assign pop  = gb_valid && gb_ready;

    result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (tpu_DO),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

    assign gb_valid  = !fifo_empty;
    assign gb_data   = gb_valid ? relu_row(head, relu_q) : '0;
    assign gb_addr   = base_q + out_cnt_q * ADDR_W'(ADDR_STRIDE);
    assign busy      = busy_q;
    assign tile_done = tile_done_q;
    assign overflow  = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            base_q      <= '0;
            relu_q      <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            if (pop) out_cnt_q <= out_cnt_q + 1'b1;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            case (state_q)
                // FIFO is always empty here, so restarting out_cnt cannot race a pop.
                IDLE, FINISH: begin
                    if (tpu_out_valid) begin
                        base_q    <= base_addr;
                        relu_q    <= relu_en;
                        in_cnt_q  <= CNT_W'(1);
                        out_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= tpu_done ? DRAIN : COLLECT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                COLLECT: begin
                    if (tpu_out_valid) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (tpu_done || in_cnt_q == CNT_W'(ROWS - 1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty || (pop && fifo_cnt == (FPW+1)'(1))) begin
                        state_q     <= FINISH;
                        busy_q      <= 1'b0;
                        tile_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_result_writer.sv
// Directed + randomized bench for tpu_result_writer against a queue-based reference model.
module tb_tpu_result_writer;
    import tpu_result_writer_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              tpu_out_valid = 1'b0;
    logic [DATA_W-1:0] tpu_DO = '0;
    logic              tpu_done = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              relu_en = 1'b0;
    logic              gb_valid;
    logic [ADDR_W-1:0] gb_addr;
    logic [DATA_W-1:0] gb_data;
    logic              gb_ready = 1'b0;
    logic              busy, tile_done, overflow;

    tpu_result_writer dut (
        .clk(clk), .rst(rst), .tpu_out_valid(tpu_out_valid), .tpu_DO(tpu_DO),
        .tpu_done(tpu_done), .base_addr(base_addr), .relu_en(relu_en),
        .gb_valid(gb_valid), .gb_addr(gb_addr), .gb_data(gb_data), .gb_ready(gb_ready),
        .busy(busy), .tile_done(tile_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, nwr = 0, ndone = 0, kept_m = 0;

    // Reference model: expected buffer contents as already-transformed writes.
    logic [DATA_W-1:0] q[$];
    bit                coll, drn, td_m, ovf_m, relu_m;
    int                rows_m;
    logic [ADDR_W-1:0] base_m, wcnt_m;

    function automatic logic [DATA_W-1:0] ref_relu(input logic [DATA_W-1:0] d, input bit en);
        logic [DATA_W-1:0] r;
        byte b;
        r = d;
        for (int k = 0; k < LANES; k++) begin
            b = d[8*k +: 8];
            if (en && b < 0) r[8*k +: 8] = 8'h00;
        end
        return r;
    endfunction

    function automatic void model_reset();
        q.delete();
        coll = 0; drn = 0; td_m = 0; ovf_m = 0; relu_m = 0;
        rows_m = 0; base_m = '0; wcnt_m = '0;
    endfunction

    function automatic void model_edge();
        int  sz;
        bit  pop, nxt_td;
        sz = q.size();
        pop = (sz > 0) && gb_ready;
        nxt_td = 0;
        if (pop) begin
            void'(q.pop_front());
            wcnt_m = wcnt_m + 1'b1;
        end
        if (drn) begin
            if (sz == 0 || (pop && sz == 1)) begin drn = 0; nxt_td = 1; end
        end else if (tpu_out_valid) begin
            if (!coll) begin
                coll = 1; base_m = base_addr; relu_m = relu_en; rows_m = 0; wcnt_m = '0;
            end
            rows_m++;
            if (sz < FIFO_DEPTH || pop) begin
                q.push_back(ref_relu(tpu_DO, relu_m));
                kept_m++;
            end else begin
                ovf_m = 1;
            end
            if (tpu_done || rows_m == ROWS) begin coll = 0; drn = 1; end
        end
        td_m = nxt_td;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [ADDR_W-1:0] ea;
        ea = base_m + wcnt_m;
        chk("gb_valid", gb_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("gb_addr", gb_addr, ea);
            chk("gb_data", gb_data, q[0]);
        end
        chk("busy", busy, coll || drn);
        chk("tile_done", tile_done, td_m);
        chk("overflow", overflow, ovf_m);
    endtask

    // Called at posedge+1: drive, check current cycle, then advance one edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit dn, input bit rdy);
        tpu_out_valid = v; tpu_DO = d; tpu_done = dn; gb_ready = rdy;
        #1;
        check_outputs();
        if (gb_valid && gb_ready) nwr++;
        if (tile_done) ndone++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, '0, 1'b0, rdy);
    endtask

    function automatic logic [DATA_W-1:0] rnd_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, gb_valid, 1'b0);
        chk({tag, "_addr"}, gb_addr, '0);
        chk({tag, "_data"}, gb_data, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_tdone"}, tile_done, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        int rows;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Full tile, no ReLU, row index replicated per byte.
        base_addr = 16'h0100; relu_en = 1'b0; nwr = 0; ndone = 0;
        for (int i = 0; i < ROWS; i++) begin
            b = 8'(i);
            step(1'b1, {16{b}}, i == ROWS - 1, 1'b1);
        end
        idle(4, 1'b1);
        chk("t1_writes", nwr, 16);
        chk("t1_done", ndone, 1);
        chk("t1_ovf", overflow, 1'b0);

        // ReLU; base/relu inputs change after the first row and must be ignored.
        base_addr = 16'h2000; relu_en = 1'b1; nwr = 0; ndone = 0;
        step(1'b1, {8{16'h7F80}}, 1'b0, 1'b1);
        chk("relu_alt", gb_data, {8{16'h7F00}});
        base_addr = 16'h5555; relu_en = 1'b0;
        step(1'b1, {16{8'hFF}}, 1'b0, 1'b1);
        chk("relu_ff_valid", gb_valid, 1'b1);
        chk("relu_ff", gb_data, '0);
        for (int i = 2; i < ROWS; i++) step(1'b1, rnd_row(), i == ROWS - 1, 1'b1);
        idle(4, 1'b1);
        chk("t2_writes", nwr, 16);
        chk("t2_done", ndone, 1);

        // Backpressure: ready 1,0,0 repeating, one row every third cycle.
        base_addr = 16'h3000; relu_en = 1'b0; nwr = 0; ndone = 0; rows = 0;
        for (int c = 0; c < 48; c++) begin
            if (c % 3 == 0 && rows < ROWS) begin
                rows++;
                step(1'b1, rnd_row(), rows == ROWS, 1'b1);
            end else begin
                step(1'b0, '0, 1'b0, 1'b0);
            end
        end
        idle(6, 1'b1);
        chk("t3_writes", nwr, 16);
        chk("t3_done", ndone, 1);

        // Short tile of 8 rows, then a wrapping tile whose first row lands in FINISH.
        base_addr = 16'h0040; nwr = 0; ndone = 0;
        for (int i = 0; i < 8; i++) step(1'b1, rnd_row(), i == 7, 1'b1);
        idle(1, 1'b1);
        base_addr = 16'hFFF8; relu_en = 1'b1;
        step(1'b1, rnd_row(), 1'b0, 1'b1);
        chk("wrap_first", gb_addr, 16'hFFF8);
        for (int i = 1; i < ROWS; i++) step(1'b1, rnd_row(), i == ROWS - 1, 1'b1);
        idle(4, 1'b1);
        chk("t45_writes", nwr, 24);
        chk("t45_done", ndone, 2);

        // Overflow: ready low for 20 cycles, six rows arrive.
        base_addr = 16'h0300; relu_en = 1'b0; nwr = 0; ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rnd_row(), i == 5, 1'b0);
            if (i == 3) chk("ovf_after_4", overflow, 1'b0);
            if (i == 4) chk("ovf_after_5", overflow, 1'b1);
        end
        idle(14, 1'b0);
        idle(8, 1'b1);
        chk("t6_writes", nwr, 4);
        chk("t6_done", ndone, 1);
        chk("t6_ovf_sticky", overflow, 1'b1);

        // Reset mid-tile after 5 rows.
        base_addr = 16'h0400; nwr = 0; ndone = 0;
        for (int i = 0; i < 5; i++) step(1'b1, rnd_row(), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_reset_values("midrst");
        tpu_out_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_done", ndone, 0);

        // Randomized tile: random gaps, random ready, inputs churn every cycle.
        nwr = 0; ndone = 0; kept_m = 0; rows = 0;
        base_addr = 16'($urandom()); relu_en = 1'($urandom());
        for (int c = 0; c < 200 && rows < ROWS; c++) begin
            bit v;
            v = 1'($urandom());
            if (v) rows++;
            step(v, rnd_row(), v && rows == ROWS, $urandom_range(0, 3) != 0);
            base_addr = 16'($urandom()); relu_en = 1'($urandom());
        end
        idle(12, 1'b1);
        chk("rnd_rows_sent", rows, 16);
        chk("rnd_writes", nwr, kept_m);
        chk("rnd_done", ndone, 1);
        chk("rnd_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
